uc_sequencer: RTL and testbench

Parametrised program sequencer for the 8-bit microcontroller family. It replaces the plain program counter and adds three things: a hardware call/return stack, a counted bootstrap phase, and fault detection with halt and recovery. It sits between the control unit (which issues `pc_inc`/`pc_load`/`call`/`ret` and supplies `pc_next`) and the flash address bus (driven by `pc_out`). All state advances only on `clk` edges where `clk_valid` is high.

---
 rtl/uc_sequencer.sv | 126 ++++++++++++
 tb/tb_uc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uc_sequencer.sv
// Program sequencer: program counter with hardware call/return stack,
// counted bootstrap phase, and stack-fault halt with software recovery.
module uc_sequencer #(
  parameter  int ADDR_WIDTH  = 12,
  parameter  int STACK_DEPTH = 8,
  parameter  int BOOT_CYCLES = 4,
  localparam int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clk_valid,
  input  logic                  pc_inc,
  input  logic                  pc_load,
  input  logic                  call,
  input  logic                  ret,
  input  logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  fault_clr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  bootstrapping,
  output logic [1:0]            state,
  output logic [LVL_W-1:0]      stack_level,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t                  st;
  logic [CNT_W-1:0]        boot_cnt;
  logic [ADDR_WIDTH-1:0]   stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]        push_idx;
  logic [IDX_W-1:0]        pop_idx;
  logic [ADDR_WIDTH-1:0]   top_addr;
  logic [ADDR_WIDTH-1:0]   ret_addr;
  logic                    push_en;

  // Address increment wraps naturally modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  assign state       = st;
  assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
  assign stack_empty = (stack_level == '0);
  assign push_idx    = IDX_W'(stack_level);
  assign pop_idx     = IDX_W'(stack_level - LVL_W'(1));
  assign top_addr    = stack_mem[pop_idx];
  assign ret_addr    = addr_inc(pc_out);

  // ret outranks call, so a push happens only when ret is absent.
  assign push_en = clk_valid && (st == ST_RUN) && !ret && call && !stack_full;

  // Stack storage carries no reset; only entries below stack_level are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= ret_addr;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      st              <= ST_BOOT;
      pc_out          <= '0;
      stack_level     <= '0;
      boot_cnt        <= '0;
      bootstrapping   <= 1'b1;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (clk_valid) begin
      case (st)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + CNT_W'(1);
          if (boot_cnt == CNT_W'(BOOT_CYCLES - 1)) begin
            st            <= ST_RUN;
            bootstrapping <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ret) begin
            if (stack_empty) begin
              stack_underflow <= 1'b1;
              st              <= ST_HALT;
            end else begin
              pc_out      <= top_addr;
              stack_level <= stack_level - LVL_W'(1);
            end
          end else if (call) begin
            if (stack_full) begin
              stack_overflow <= 1'b1;
              st             <= ST_HALT;
            end else begin
              pc_out      <= pc_next;
              stack_level <= stack_level + LVL_W'(1);
            end
          end else if (pc_load) begin
            pc_out <= pc_next;
          end else if (pc_inc) begin
            pc_out <= addr_inc(pc_out);
          end
        end
        ST_HALT: begin
          if (fault_clr) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            st              <= ST_RUN;
          end
        end
        default: begin
          st            <= ST_HALT;
          bootstrapping <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer: boot, call/return, wrap, nesting, faults,
// stalls and asynchronous reset, with hand-computed expectations.
module tb_uc_sequencer;

  localparam int AW = 12;
  localparam int SD = 4;
  localparam int BC = 3;
  localparam int LW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          arst;
  logic          clk_valid;
  logic          pc_inc, pc_load, call, ret, fault_clr;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_out;
  logic          bootstrapping;
  logic [1:0]    state;
  logic [LW-1:0] stack_level;
  logic          stack_full, stack_empty, stack_overflow, stack_underflow;

  int checks = 0;
  int failures = 0;

  uc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .BOOT_CYCLES(BC)) dut (
    .clk(clk), .arst(arst), .clk_valid(clk_valid),
    .pc_inc(pc_inc), .pc_load(pc_load), .call(call), .ret(ret),
    .pc_next(pc_next), .fault_clr(fault_clr),
    .pc_out(pc_out), .bootstrapping(bootstrapping), .state(state),
    .stack_level(stack_level), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cmd(input logic i, input logic l, input logic c, input logic r,
                     input logic [AW-1:0] nxt, input logic fc);
    pc_inc = i; pc_load = l; call = c; ret = r; pc_next = nxt; fault_clr = fc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; clk_valid = 1'b0;
    cmd(0, 0, 0, 0, '0, 0);
    #3;
    checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", pc_out); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (bootstrapping !== 1'b1) begin failures++; $display("FAIL reset_boot got=%b exp=1", bootstrapping); end
    checks++; if (stack_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", stack_level); end
    checks++; if ({stack_empty, stack_full} !== 2'b10) begin failures++; $display("FAIL reset_empty_full got=%b exp=10", {stack_empty, stack_full}); end
    checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {stack_overflow, stack_underflow}); end
  endtask

  task automatic test_boot();
    arst = 1'b0;
    cmd(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      clk_valid = (i % 2 == 0);
      tick();
      checks++; if (bootstrapping !== (i < 4)) begin failures++; $display("FAIL boot_flag step=%0d got=%b exp=%b", i, bootstrapping, (i < 4)); end
      checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL boot_pc step=%0d got=%h exp=000", i, pc_out); end
    end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL boot_state got=%0d exp=1", state); end
    clk_valid = 1'b1;
    tick();
    checks++; if (pc_out !== 12'h001) begin failures++; $display("FAIL boot_first_inc got=%h exp=001", pc_out); end
  endtask

  task automatic test_call_ret();
    cmd(0, 1, 0, 0, 12'h010, 0); tick();
    checks++; if (pc_out !== 12'h010) begin failures++; $display("FAIL load_pc got=%h exp=010", pc_out); end
    cmd(0, 0, 1, 0, 12'h200, 0); tick();
    checks++; if (pc_out !== 12'h200) begin failures++; $display("FAIL call_pc got=%h exp=200", pc_out); end
    checks++; if (stack_level !== 3'd1) begin failures++; $display("FAIL call_level got=%0d exp=1", stack_level); end
    checks++; if (stack_empty !== 1'b0) begin failures++; $display("FAIL call_empty got=%b exp=0", stack_empty); end
    cmd(1, 0, 0, 0, '0, 0); tick(); tick();
    checks++; if (pc_out !== 12'h202) begin failures++; $display("FAIL inc_pc got=%h exp=202", pc_out); end
    cmd(0, 0, 0, 1, '0, 0); tick();
    checks++; if (pc_out !== 12'h011) begin failures++; $display("FAIL ret_pc got=%h exp=011", pc_out); end
    checks++; if (stack_level !== 3'd0 || stack_empty !== 1'b1) begin failures++; $display("FAIL ret_level got=%0d/%b exp=0/1", stack_level, stack_empty); end
  endtask

  task automatic test_wrap_nesting();
    logic [AW-1:0] tgt [4];
    logic [AW-1:0] rta [4];
    tgt[0] = 12'h100; tgt[1] = 12'h180; tgt[2] = 12'h1C0; tgt[3] = 12'h1E0;
    rta[0] = 12'h000; rta[1] = 12'h101; rta[2] = 12'h181; rta[3] = 12'h1C1;
    cmd(0, 1, 0, 0, 12'hFFF, 0); tick();
    cmd(1, 0, 0, 0, '0, 0); tick();
    checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL inc_wrap got=%h exp=000", pc_out); end
    cmd(0, 1, 0, 0, 12'hFFF, 0); tick();
    for (int i = 0; i < 4; i++) begin
      cmd(0, 0, 1, 0, tgt[i], 0); tick();
      checks++; if (pc_out !== tgt[i] || stack_level !== LW'(i + 1)) begin failures++; $display("FAIL nest_call%0d got=%h/%0d exp=%h/%0d", i, pc_out, stack_level, tgt[i], i + 1); end
    end
    checks++; if (stack_full !== 1'b1) begin failures++; $display("FAIL nest_full got=%b exp=1", stack_full); end
    for (int i = 3; i >= 0; i--) begin
      cmd(0, 0, 0, 1, '0, 0); tick();
      checks++; if (pc_out !== rta[i] || stack_level !== LW'(i)) begin failures++; $display("FAIL nest_ret%0d got=%h/%0d exp=%h/%0d", i, pc_out, stack_level, rta[i], i); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      cmd(0, 0, 1, 0, AW'(i * 16), 0); tick();
    end
    checks++; if (pc_out !== 12'h040 || stack_level !== 3'd4) begin failures++; $display("FAIL ovf_setup got=%h/%0d exp=040/4", pc_out, stack_level); end
    cmd(0, 0, 1, 0, 12'h300, 0); tick();
    checks++; if (stack_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", stack_overflow); end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL ovf_state got=%0d exp=2", state); end
    checks++; if (pc_out !== 12'h040 || stack_level !== 3'd4) begin failures++; $display("FAIL ovf_hold got=%h/%0d exp=040/4", pc_out, stack_level); end
    cmd(1, 0, 0, 0, '0, 0); tick();
    cmd(0, 0, 0, 1, '0, 0); tick();
    checks++; if (pc_out !== 12'h040 || stack_level !== 3'd4 || state !== 2'd2) begin failures++; $display("FAIL halt_ignore got=%h/%0d/%0d exp=040/4/2", pc_out, stack_level, state); end
    cmd(0, 0, 0, 0, '0, 1); tick();
    checks++; if (state !== 2'd1 || stack_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%0d/%b exp=1/0", state, stack_overflow); end
    checks++; if (stack_level !== 3'd4 || pc_out !== 12'h040) begin failures++; $display("FAIL ovf_resume got=%h/%0d exp=040/4", pc_out, stack_level); end
    cmd(0, 0, 0, 1, '0, 0); tick();
    checks++; if (pc_out !== 12'h031 || stack_level !== 3'd3) begin failures++; $display("FAIL ovf_ret got=%h/%0d exp=031/3", pc_out, stack_level); end
    tick(); tick(); tick();
    checks++; if (pc_out !== 12'h001 || stack_level !== 3'd0) begin failures++; $display("FAIL ovf_drain got=%h/%0d exp=001/0", pc_out, stack_level); end
  endtask

  task automatic test_underflow();
    cmd(0, 0, 1, 1, 12'h123, 0); tick();
    checks++; if (stack_underflow !== 1'b1 || state !== 2'd2) begin failures++; $display("FAIL udf_flag got=%b/%0d exp=1/2", stack_underflow, state); end
    checks++; if (pc_out !== 12'h001 || stack_level !== 3'd0) begin failures++; $display("FAIL udf_nopush got=%h/%0d exp=001/0", pc_out, stack_level); end
    checks++; if (stack_overflow !== 1'b0) begin failures++; $display("FAIL udf_ovf got=%b exp=0", stack_overflow); end
    cmd(0, 0, 0, 0, '0, 1); tick();
    checks++; if (state !== 2'd1 || stack_underflow !== 1'b0) begin failures++; $display("FAIL udf_clr got=%0d/%b exp=1/0", state, stack_underflow); end
    cmd(1, 0, 0, 0, '0, 1); tick();
    checks++; if (state !== 2'd1 || pc_out !== 12'h002) begin failures++; $display("FAIL clr_in_run got=%0d/%h exp=1/002", state, pc_out); end
  endtask

  task automatic test_stall();
    clk_valid = 1'b0;
    cmd(0, 1, 0, 0, 12'h0AA, 0); tick();
    cmd(0, 0, 1, 0, 12'h0BB, 0); tick();
    checks++; if (pc_out !== 12'h002 || stack_level !== 3'd0) begin failures++; $display("FAIL stall_hold got=%h/%0d exp=002/0", pc_out, stack_level); end
    clk_valid = 1'b1;
    cmd(0, 1, 1, 0, 12'h0CC, 0); tick();
    checks++; if (pc_out !== 12'h0CC || stack_level !== 3'd1) begin failures++; $display("FAIL call_over_load got=%h/%0d exp=0CC/1", pc_out, stack_level); end
    cmd(0, 0, 0, 1, '0, 0); tick();
    checks++; if (pc_out !== 12'h003) begin failures++; $display("FAIL call_over_load_ret got=%h exp=003", pc_out); end
  endtask

  task automatic test_midreset();
    cmd(0, 1, 0, 0, 12'h040, 0); tick();
    cmd(0, 0, 1, 0, 12'h048, 0); tick();
    cmd(0, 0, 1, 0, 12'h055, 0); tick();
    cmd(0, 0, 0, 0, '0, 0);
    checks++; if (pc_out !== 12'h055 || stack_level !== 3'd2) begin failures++; $display("FAIL mid_setup got=%h/%0d exp=055/2", pc_out, stack_level); end
    #2 arst = 1'b1;
    #1;
    checks++; if (pc_out !== 12'h000 || stack_level !== 3'd0) begin failures++; $display("FAIL mid_reset got=%h/%0d exp=000/0", pc_out, stack_level); end
    checks++; if (bootstrapping !== 1'b1 || state !== 2'd0) begin failures++; $display("FAIL mid_boot got=%b/%0d exp=1/0", bootstrapping, state); end
    #1 arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bootstrapping !== (i < 2)) begin failures++; $display("FAIL reboot step=%0d got=%b exp=%b", i, bootstrapping, (i < 2)); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_call_ret();
    test_wrap_nesting();
    test_overflow();
    test_underflow();
    test_stall();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
